// File: rtl/store_byte_merge.sv
// rtl/store_byte_merge.sv - byte/word store engine with read-modify-write merge into 16-bit word memory
module store_byte_merge #(
  parameter int BIG_ENDIAN = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_byte,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_data,
  output logic [14:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata,
  output logic        mem_wr,
  output logic [15:0] mem_wdata,
  input  logic        mem_wack,
  output logic        done,
  output logic [1:0]  err,
  output logic        done_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    FIN     = 3'd5
  } state_t;

  localparam logic        BE_LANES = (BIG_ENDIAN != 0);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_MISALIGN  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT   = 2'b10;

  state_t      state;
  state_t      state_nxt;
  logic        accept;
  logic        lane_hi_q;
  logic [7:0]  byte_data_q;
  logic [15:0] tmo_cnt;
  logic        timed_out;
  logic        wait_expired;
  logic [15:0] merged;

  assign accept    = req_valid && (state == IDLE);
  assign timed_out = (tmo_cnt == TMO_LAST);

  // A wait state gives up only when its own response is absent on the last allowed cycle
  assign wait_expired = timed_out &&
                        (((state == RD_WAIT) && !mem_rvalid) ||
                         ((state == WR_WAIT) && !mem_wack));

  // Replace the addressed lane with the store byte, keep the other lane from memory
  assign merged = lane_hi_q ? {byte_data_q, mem_rdata[7:0]}
                            : {mem_rdata[15:8], byte_data_q};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and strobe/handshake outputs
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    done      = 1'b0;
    done_err  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_byte) begin
            state_nxt = RD_REQ;
          end else if (req_addr[0]) begin
            state_nxt = FIN;
          end else begin
            state_nxt = WR_REQ;
          end
        end
      end
      RD_REQ: begin
        mem_rd    = 1'b1;
        state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_rvalid) begin
          state_nxt = WR_REQ;
        end else if (timed_out) begin
          state_nxt = FIN;
        end
      end
      WR_REQ: begin
        mem_wr    = 1'b1;
        state_nxt = WR_WAIT;
      end
      WR_WAIT: begin
        if (mem_wack || timed_out) begin
          state_nxt = FIN;
        end
      end
      FIN: begin
        done      = (err == ERR_NONE);
        done_err  = (err != ERR_NONE);
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Wait-cycle counter: zero outside the wait states, so it is clear on every entry
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= 16'd0;
    end else if ((state == RD_WAIT) || (state == WR_WAIT)) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end else begin
      tmo_cnt <= 16'd0;
    end
  end

  // Request capture, merge write data and error status
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr    <= 15'd0;
      mem_wdata   <= 16'd0;
      err         <= ERR_NONE;
      lane_hi_q   <= 1'b0;
      byte_data_q <= 8'd0;
    end else begin
      if (accept) begin
        mem_addr    <= req_addr[15:1];
        lane_hi_q   <= req_addr[0] ^ BE_LANES;
        byte_data_q <= req_data[7:0];
        err         <= (!req_byte && req_addr[0]) ? ERR_MISALIGN : ERR_NONE;
        if (!req_byte && !req_addr[0]) begin
          mem_wdata <= req_data;
        end
      end
      if ((state == RD_WAIT) && mem_rvalid) begin
        mem_wdata <= merged;
      end
      if (wait_expired) begin
        err <= ERR_TIMEOUT;
      end
    end
  end

endmodule

// File: doc/store_byte_merge.md
Name: store_byte_merge

Overview:
- Store-path counterpart to the load-path byte zero-extender: narrows a 16-bit register value to one byte and writes it into word-organised 16-bit data memory via read-modify-write.
- Sits between the datapath's store request (SB/SW) and the single-port data memory.
- Full-word stores pass straight through as a single write; byte stores run read → merge → write.
- Includes misalignment detection and a memory-handshake timeout.

Parameters:
- BIG_ENDIAN, 0, byte-lane select: 0 means addr[0]=0 selects bits [7:0]; 1 means addr[0]=0 selects bits [15:8].
- TIMEOUT, 255, maximum cycles to wait for mem_rvalid or mem_wack before aborting; range 1..65535.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  store request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_byte  in  1  1 = byte store (SB), 0 = word store (SW).
- req_addr  in  16  byte address.
- req_data  in  16  store data; only [7:0] is used when req_byte=1.
- mem_addr  out  15  word address, equal to req_addr[15:1].
- mem_rd  out  1  one-cycle read strobe.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  16  read data.
- mem_wr  out  1  one-cycle write strobe.
- mem_wdata  out  16  write data.
- mem_wack  in  1  write acknowledged.
- done  out  1  one-cycle pulse when a store completes successfully.
- err  out  2  held with done_err: 00 none, 01 misaligned word store, 10 timeout.
- done_err  out  1  one-cycle pulse when a store is aborted.

Behaviour:
- Reset state: IDLE. All outputs 0 except req_ready=1; timeout counter 0. mem_addr and mem_wdata reset to 0.
- Acceptance: a request is accepted on a rising edge with req_valid && req_ready.
  - On acceptance, req_byte, addr[0], the word address and the data are latched.
  - Inputs are ignored in every state other than IDLE.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN.
- IDLE transitions on acceptance:
  - Word store with addr[0]=1 → FIN, err=01, no memory access.
  - Word store, aligned → WR_REQ with mem_wdata = req_data.
  - Byte store → RD_REQ.
- RD_REQ: mem_rd=1 for exactly one cycle → RD_WAIT.
- RD_WAIT: on mem_rvalid, merge the byte and go to WR_REQ.
  - Selected lane = req_data[7:0]; the other lane is taken from mem_rdata unchanged.
  - mem_rvalid in the same cycle as mem_rd is ignored; the earliest accepted rvalid is the cycle after RD_REQ.
- WR_REQ: mem_wr=1 for one cycle, with mem_wdata and mem_addr stable → WR_WAIT.
- WR_WAIT: on mem_wack → FIN, err=00.
- mem_addr holds the latched word address from acceptance until the return to IDLE.
- Timeout:
  - The counter clears on entry to RD_WAIT or WR_WAIT and increments each cycle without the expected response.
  - When count == TIMEOUT-1 and no response arrives → FIN, err=10, no write is issued.
  - A response arriving in the same cycle the count reaches TIMEOUT-1 wins (no timeout).
- FIN: lasts one cycle.
  - Pulses done (err=00) or done_err (err≠00).
  - err holds its value until the next acceptance.
  - Returns to IDLE; req_ready rises the cycle after FIN.
- Latency, zero-wait memory (response the cycle after the strobe):
  - Byte store: accept → done in 5 cycles.
  - Word store: 3 cycles.
  - Misaligned: 1 cycle.
- Stray mem_rvalid or mem_wack outside the waiting states is ignored.
- Reset asserted in any state returns to IDLE on the next edge.
  - Any in-flight strobe is dropped and no done is produced.
  - A merged word not yet strobed is never written.
- Back-to-back: a new request may be accepted in the cycle after FIN; there is no request queue.

Test Plan:
- Byte store, low lane: memory word 0xA5C3, req_byte=1, addr=0x0010, data=0x0073, BIG_ENDIAN=0 → mem_rd at word 0x0008, then mem_wdata=0xA573; done 5 cycles after acceptance, err=00.
- Byte store, high lane: memory word 0xA5C3, addr=0x0011, data=0x12FF → mem_wdata=0xFFC3. With BIG_ENDIAN=1 the same stimulus gives 0xA5FF.
- Aligned word store: addr=0x0020, data=0xBEEF → no mem_rd; mem_wr with 0xBEEF at word 0x0010; done after 3 cycles.
- Misaligned word store: addr=0x0021 → no mem_rd or mem_wr; done_err one cycle after acceptance, err=01.
- Timeout: TIMEOUT=4, byte store, mem_rvalid held low → done_err with err=10 exactly 4 cycles after entering RD_WAIT; mem_wr never asserted; req_ready high on the next cycle.
- Reset mid-operation: assert rst while in RD_WAIT, then deliver mem_rvalid the cycle after → no mem_wr, no done; outputs at reset values; a following byte store completes normally.
